mac_pause_sched: RTL
====================

MAC_PAUSE_SCHED -- requirements
Module: mac_pause_sched

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 64, TX AXI-Stream data width; only 64 is supported.
REQ-002 Parameter AXIS_DATA_BYTES, default AXIS_DATA_WIDTH/8, tkeep width.
REQ-003 Parameter LOCAL_MAC, default 48'hAA_BB_CC_DD_EE_FF, source address of generated pause frames.
REQ-004 Parameter QUANTUM_CYCLES, default 8, mac_clk cycles per pause quantum (512 bit times at 64 bits/cycle).
REQ-005 Clock, reset and ports:
- mac_clk  in  1  sole clock.
- mac_rst  in  1  synchronous, active-high reset.
- s_axis_tdata/tkeep/tvalid/tlast  in  64/8/1/1  user TX stream.
- s_axis_tready  out  1  user TX ready.
- m_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  stream to TX MAC.
- m_axis_tready  in  1  TX MAC ready.
- pause_req  in  1  one-cycle request to send a pause frame.
- pause_time  in  16  quanta for the requested frame.
- rx_pause_valid  in  1  one-cycle strobe: a pause frame was received.
- rx_pause_time  in  16  received quanta.
- pause_frame_sent  out  1  one-cycle pulse after the last pause beat is accepted.
- tx_paused  out  1  high while the received-pause counter is nonzero.
- pause_remaining  out  19  current counter value in cycles.

Function
REQ-006 FSM states are IDLE, USER and PAUSE_TX; arbitration happens only in IDLE, never mid-frame.
REQ-007 In IDLE: a pending pause request goes to PAUSE_TX; else s_axis_tvalid with tx_paused=0 goes to USER; else stay in IDLE; m_axis_tvalid=0 and s_axis_tready=0.
REQ-008 In USER: combinational pass-through (m_axis_* = s_axis_*, s_axis_tready = m_axis_tready); zero latency; go to IDLE on an accepted beat with tlast=1.
REQ-009 pause_req=1 latches pending=1 and pause_time; a later pause_req before transmission overwrites the latched time; pending clears on entry to PAUSE_TX.
REQ-010 PAUSE_TX emits 8 beats (60 bytes, byte 0 in tdata[7:0]); beats advance only on m_axis_tvalid&&m_axis_tready.
- beat0: DA 01-80-C2-00-00-01, then LOCAL_MAC bytes 47:40, 39:32.
- beat1: LOCAL_MAC bytes 31:0 MSB first, then 88 08 00 01.
- beat2: pause_time[15:8], pause_time[7:0], then zeros.
- beats3-7: zeros.
- tkeep=FF on beats 0-6; tkeep=0F and tlast=1 on beat 7.
REQ-011 The latched time is sampled on entry to PAUSE_TX and held constant for the whole frame.
REQ-012 After beat 7 is accepted: pause_frame_sent=1 for the next cycle, then IDLE; a pause_req during PAUSE_TX sets pending for a following frame.
REQ-013 rx_pause_valid loads the counter with rx_pause_time*QUANTUM_CYCLES (19-bit, no overflow); otherwise a nonzero counter decrements by 1 per cycle, saturating at 0.
REQ-014 A new rx_pause_valid reloads the counter even if nonzero; a value of 0 resumes TX immediately.
REQ-015 tx_paused blocks only the start of user frames; an in-progress user frame completes; pause frames are sent regardless of tx_paused.
REQ-016 If pause_req and s_axis_tvalid are both present in IDLE, the pause frame wins.

Reset
REQ-017 mac_rst=1 at a clock edge forces:
- state IDLE, pending=0, counter=0, beat index=0;
- outputs m_axis_tvalid=0, s_axis_tready=0, pause_frame_sent=0, tx_paused=0, pause_remaining=0, m_axis_tdata/tkeep/tlast=0.
REQ-018 Reset mid-frame truncates the frame without emitting tlast; no pause_frame_sent pulse is generated.

Configuration
REQ-019 Macro MAC_PAUSE_RX_EN: when defined, REQ-013..015 apply.
REQ-020 When MAC_PAUSE_RX_EN is undefined: rx_pause_valid and rx_pause_time are ignored, tx_paused=0, pause_remaining=0, and no counter logic is built; pause frame generation is unaffected.

Verification
REQ-021 Bench must cover:
- 3-beat user frame, m_axis_tready=1 -> identical beats on m_axis, same cycles, tlast on beat 3, state returns to IDLE.
- pause_req with pause_time=16'h1234 in IDLE -> 8 beats; beat2 tdata[15:0]=16'h3412; beat7 tkeep=8'h0F; pause_frame_sent pulses once.
- pause_req during a 5-beat user frame -> user frame completes unbroken, then the pause frame follows.
- rx_pause_time=2 -> tx_paused high for exactly 16 cycles; a user frame offered meanwhile starts only after tx_paused falls.
- rx_pause_time=100, then rx_pause_time=0 five cycles later -> tx_paused drops the next cycle; pause_req while paused is still sent.
- m_axis_tready toggling 1/0 during PAUSE_TX -> beats are neither repeated nor skipped; reset asserted at beat 4 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mac_pause_sched.sv
// TX arbiter: forwards user AXI-Stream frames and injects locally generated 802.3x pause frames between them.
// Define MAC_PAUSE_RX_EN to build the received-pause counter that holds off the start of new user frames.
module mac_pause_sched #(
  parameter int          AXIS_DATA_WIDTH = 64,
  parameter int          AXIS_DATA_BYTES = AXIS_DATA_WIDTH/8,
  parameter logic [47:0] LOCAL_MAC       = 48'hAA_BB_CC_DD_EE_FF,
  parameter int          QUANTUM_CYCLES  = 8
) (
  input  logic                       mac_clk,
  input  logic                       mac_rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_DATA_BYTES-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_DATA_BYTES-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       pause_req,
  input  logic [15:0]                pause_time,
  input  logic                       rx_pause_valid,
  input  logic [15:0]                rx_pause_time,
  output logic                       pause_frame_sent,
  output logic                       tx_paused,
  output logic [18:0]                pause_remaining
);

  typedef enum logic [1:0] {IDLE, USER, PAUSE_TX} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_pend;
  logic [15:0]                r_ptime;
  logic [15:0]                r_ftime;
  logic [2:0]                 r_beat;
  logic                       r_sent;
  logic                       w_pend;
  logic [15:0]                w_ptime;
  logic                       w_start_pause;
  logic                       w_beat_acc;
  logic [AXIS_DATA_WIDTH-1:0] w_pdata;
  logic [AXIS_DATA_BYTES-1:0] w_pkeep;

  // A request arriving in the IDLE cycle itself wins arbitration, so fold it in combinationally.
  assign w_pend        = r_pend | pause_req;
  assign w_ptime       = pause_req ? pause_time : r_ptime;
  assign w_start_pause = (r_state == IDLE) && w_pend;
  assign w_beat_acc    = (r_state == PAUSE_TX) && m_axis_tready;

  always_ff @(posedge mac_clk) begin
    if (mac_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pend)                           w_next = PAUSE_TX;
        else if (s_axis_tvalid && !tx_paused) w_next = USER;
      end
      USER:     if (s_axis_tvalid && m_axis_tready && s_axis_tlast) w_next = IDLE;
      PAUSE_TX: if (w_beat_acc && (r_beat == 3'd7))                 w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge mac_clk) begin
    if (mac_rst) begin
      r_pend  <= 1'b0;
      r_ptime <= '0;
      r_ftime <= '0;
      r_beat  <= '0;
      r_sent  <= 1'b0;
    end else begin
      r_sent <= w_beat_acc && (r_beat == 3'd7);
      if (w_start_pause) begin
        r_pend  <= 1'b0;
        r_ftime <= w_ptime;
        r_beat  <= '0;
      end else begin
        if (pause_req) begin
          r_pend  <= 1'b1;
          r_ptime <= pause_time;
        end
        if (w_beat_acc) r_beat <= r_beat + 3'd1;
      end
    end
  end

  // Pause frame image, byte 0 of each beat in the low byte lane.
  always_comb begin
    w_pdata = '0;
    w_pkeep = '1;
    case (r_beat)
      3'd0: w_pdata = {LOCAL_MAC[39:32], LOCAL_MAC[47:40], 48'h01_00_00_C2_80_01};
      3'd1: w_pdata = {32'h01_00_08_88, LOCAL_MAC[7:0], LOCAL_MAC[15:8],
                       LOCAL_MAC[23:16], LOCAL_MAC[31:24]};
      3'd2: w_pdata = {48'h0, r_ftime[7:0], r_ftime[15:8]};
      3'd7: w_pkeep = 8'h0F;
      default: ;
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      USER: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
      end
      PAUSE_TX: begin
        m_axis_tdata  = w_pdata;
        m_axis_tkeep  = w_pkeep;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (r_beat == 3'd7);
      end
      default: ;
    endcase
  end

  assign pause_frame_sent = r_sent;

`ifdef MAC_PAUSE_RX_EN
  logic [18:0] r_cnt;

  always_ff @(posedge mac_clk) begin
    if (mac_rst)             r_cnt <= '0;
    else if (rx_pause_valid) r_cnt <= 19'(rx_pause_time) * 19'(QUANTUM_CYCLES);
    else if (r_cnt != '0)    r_cnt <= r_cnt - 19'd1;
  end

  assign tx_paused       = (r_cnt != '0);
  assign pause_remaining = r_cnt;
`else
  logic w_unused;
  assign w_unused        = ^{rx_pause_valid, rx_pause_time};
  assign tx_paused       = 1'b0;
  assign pause_remaining = '0;
`endif

endmodule
